// File: rtl/cpu_step_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer: owns pc and ir, handshakes with
// instruction and data memory, and strobes the register-file write in WB.
module cpu_step_sequencer #(
  parameter int PC_W      = 8,
  parameter int HALT_ADDR = 200,
  parameter int INSTR_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_load,
  input  logic               reg_write_flag,
  input  logic               mem_read_flag,
  input  logic               mem_write_flag,
  input  logic [2:0]         branch_dest,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               reg_we,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0]      BR_HALT = 3'd6;
  localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               next_state_s;
  logic [PC_W-1:0]      pc_r;
  logic [PC_W-1:0]      next_pc_s;
  logic [PC_W-1:0]      pc_inc_s;
  logic [INSTR_W-1:0]   ir_r;
  logic                 ir_load_r;
  logic                 reg_we_r;
  logic                 dmem_we_r;
  logic                 fetch_done_s;
  logic                 mem_access_s;
  logic                 enter_wb_s;

  assign fetch_done_s = (state_r == ST_FETCH) && imem_ack;
  assign mem_access_s = mem_read_flag || mem_write_flag;
  // WB is entered either straight from DECODE or on the closing MEM ack.
  assign enter_wb_s   = ((state_r == ST_DECODE) && !mem_access_s) ||
                        ((state_r == ST_MEM) && dmem_ack);
  assign pc_inc_s     = pc_r + PC_ONE;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (mem_access_s) begin
          next_state_s = ST_MEM;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        if (branch_dest == BR_HALT) begin
          next_state_s = ST_HALT;
        end else if (run) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // PC update, evaluated only in WB; reserved code 7 behaves as sequential.
  always_comb begin
    next_pc_s = pc_r;
    if (state_r == ST_WB) begin
      case (branch_dest)
        3'd0: begin
          next_pc_s = pc_inc_s;
        end
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
          if (branch_taken) begin
            next_pc_s = branch_target;
          end else begin
            next_pc_s = pc_inc_s;
          end
        end
        3'd6: begin
          next_pc_s = HALT_PC;
        end
        default: begin
          next_pc_s = pc_inc_s;
        end
      endcase
    end else begin
      next_pc_s = pc_r;
    end
  end

  // Program counter and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= {PC_W{1'b0}};
      ir_r <= {INSTR_W{1'b0}};
    end else begin
      pc_r <= next_pc_s;
      if (fetch_done_s) begin
        ir_r <= imem_rdata;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

  // Registered strobes: ir_load aligns with the new ir, reg_we with WB.
  // dmem_we is captured in DECODE because the flags are stable from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_load_r <= 1'b0;
      reg_we_r  <= 1'b0;
      dmem_we_r <= 1'b0;
    end else begin
      ir_load_r <= fetch_done_s;
      reg_we_r  <= enter_wb_s && reg_write_flag;
      if (state_r == ST_DECODE) begin
        dmem_we_r <= mem_write_flag && !mem_read_flag;
      end else if ((state_r == ST_MEM) && !dmem_ack) begin
        dmem_we_r <= dmem_we_r;
      end else begin
        dmem_we_r <= 1'b0;
      end
    end
  end

  assign pc       = pc_r;
  assign ir       = ir_r;
  assign ir_load  = ir_load_r;
  assign reg_we   = reg_we_r;
  assign dmem_we  = dmem_we_r;
  assign imem_req = (state_r == ST_FETCH);
  assign dmem_req = (state_r == ST_MEM);
  assign busy     = (state_r != ST_IDLE) && (state_r != ST_HALT);
  assign halted   = (state_r == ST_HALT);

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Scoreboard bench for cpu_step_sequencer: directed programs with hand-computed
// fetch addresses, latencies, data-memory transactions and register writes.
module tb_cpu_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        ir_load;
  logic        reg_write_flag;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic [2:0]  branch_dest;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        reg_we;
  logic        busy;
  logic        halted;

  logic        stray;
  logic [15:0] imem [256];
  int          dwait [256];
  int          dcnt;
  int          cyc = 0;

  always #5 clk = ~clk;

  cpu_step_sequencer #(.PC_W(8), .HALT_ADDR(200), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .ir_load(ir_load),
    .reg_write_flag(reg_write_flag), .mem_read_flag(mem_read_flag),
    .mem_write_flag(mem_write_flag), .branch_dest(branch_dest),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .busy(busy), .halted(halted)
  );

  // Toy control decode: [15] reg_write [14] mem_read [13] mem_write
  // [12:10] branch_dest [9] taken [7:0] target.
  assign reg_write_flag = ir[15];
  assign mem_read_flag  = ir[14];
  assign mem_write_flag = ir[13];
  assign branch_dest    = ir[12:10];
  assign branch_taken   = ir[9];
  assign branch_target  = ir[7:0];
  assign imem_rdata     = imem[pc];
  assign imem_ack       = imem_req | stray;
  assign dmem_ack       = dmem_req && (dcnt >= dwait[pc]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt <= 0;
    else if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] pc; logic [15:0] ir; int gap; } ir_exp_t;
  typedef struct { logic we; int len; } dm_exp_t;
  ir_exp_t    ir_q[$];
  logic [7:0] rw_q[$];
  dm_exp_t    dm_q[$];
  ir_exp_t    ie;
  dm_exp_t    de;
  logic [7:0] rpc;
  int         n_vec = 0;
  int         n_err = 0;
  int         last_load = 0;
  int         dlen = 0;
  int         guard;
  logic       reqs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ir(input logic [7:0] p, input logic [15:0] w, input int gap);
    ir_exp_t e;
    e.pc = p; e.ir = w; e.gap = gap;
    ir_q.push_back(e);
  endtask

  task automatic push_dm(input logic we, input int len);
    dm_exp_t e;
    e.we = we; e.len = len;
    dm_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents ir_load, reg_we or a dmem ack.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dlen = 0;
      end else begin
        if (ir_load) begin
          if (ir_q.size() == 0) begin
            check("ir_load_spurious", 32'(ir_q.size()), 32'd1);
          end else begin
            ie = ir_q.pop_front();
            check("fetch_pc", {24'd0, pc}, {24'd0, ie.pc});
            check("ir_word", {16'd0, ir}, {16'd0, ie.ir});
            if (ie.gap != 0) check("latency", cyc - last_load, ie.gap);
          end
          last_load = cyc;
        end
        if (reg_we) begin
          if (rw_q.size() == 0) begin
            check("reg_we_spurious", 32'(rw_q.size()), 32'd1);
          end else begin
            rpc = rw_q.pop_front();
            check("reg_we_pc", {24'd0, pc}, {24'd0, rpc});
          end
        end
        if (dmem_req) begin
          dlen++;
          if (dmem_ack) begin
            if (dm_q.size() == 0) begin
              check("dmem_spurious", 32'(dm_q.size()), 32'd1);
            end else begin
              de = dm_q.pop_front();
              check("dmem_we", {31'd0, dmem_we}, {31'd0, de.we});
              check("dmem_req_len", dlen, de.len);
            end
            dlen = 0;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dwait[i] = 0;
    end
    imem[8'h00] = 16'h0011;  imem[8'h01] = 16'h0022;
    imem[8'h02] = 16'hC033;  imem[8'h03] = 16'h0E40;
    imem[8'h40] = 16'h0E10;  imem[8'h10] = 16'h0C55;
    imem[8'h11] = 16'h2001;  imem[8'h12] = 16'hE012;
    imem[8'h13] = 16'h1E99;  imem[8'h14] = 16'h0EFF;
    imem[8'hFF] = 16'h4000;
    dwait[8'h02] = 2;
    dwait[8'hFF] = 2;
    rst_n = 1'b0; run = 1'b0; stray = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_pc_ir", {8'd0, pc, ir}, 32'd0);
    check("reset_outputs", {25'd0, imem_req, dmem_req, dmem_we, ir_load, reg_we, busy, halted}, 32'd0);

    push_ir(8'h00, 16'h0011, 0); push_ir(8'h01, 16'h0022, 3);
    push_ir(8'h02, 16'hC033, 3); push_ir(8'h03, 16'h0E40, 6);
    push_ir(8'h40, 16'h0E10, 3); push_ir(8'h10, 16'h0C55, 3);
    push_ir(8'h11, 16'h2001, 3); push_ir(8'h12, 16'hE012, 4);
    push_ir(8'h13, 16'h1E99, 4); push_ir(8'h14, 16'h0EFF, 3);
    push_ir(8'hFF, 16'h4000, 3);
    rw_q.push_back(8'h02); rw_q.push_back(8'h12);
    push_dm(1'b0, 3); push_dm(1'b1, 1); push_dm(1'b0, 1); push_dm(1'b0, 3);

    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); run = 1'b1;
    guard = 0;
    while (!(dmem_req && pc == 8'hFF) && guard < 200) begin @(negedge clk); guard++; end
    check("reach_mem_ff", {23'd0, dmem_req, pc}, {23'd0, 1'b1, 8'hFF});
    check("busy_in_mem", {31'd0, busy}, 32'd1);
    run = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk); guard++; end
    check("wrap_pc_idle", {21'd0, busy, halted, imem_req, pc}, 32'd0);
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ignores_ack", {15'd0, imem_req, ir}, {15'd0, 1'b0, 16'h4000});
    stray = 1'b0;
    check("drained_1", 32'(ir_q.size() + rw_q.size() + dm_q.size()), 32'd0);

    imem[8'h03] = 16'h0400; imem[8'h04] = 16'h8044; imem[8'h05] = 16'h1800;
    push_ir(8'h00, 16'h0011, 0); push_ir(8'h01, 16'h0022, 3);
    push_ir(8'h02, 16'hC033, 3); push_ir(8'h03, 16'h0400, 6);
    push_ir(8'h04, 16'h8044, 3); push_ir(8'h05, 16'h1800, 3);
    rw_q.push_back(8'h02); rw_q.push_back(8'h04);
    push_dm(1'b0, 3);
    run = 1'b1;
    guard = 0;
    while (!halted && guard < 100) begin @(negedge clk); guard++; end
    check("halt_pc", {24'd0, pc}, 32'd200);
    check("halt_flags", {28'd0, halted, busy, imem_req, dmem_req}, 32'h8);
    stray = 1'b1;
    reqs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run = i[0];
      @(negedge clk);
      reqs = reqs | imem_req | dmem_req;
    end
    check("halt_no_fetch", {22'd0, reqs, halted, pc}, {22'd0, 1'b0, 1'b1, 8'd200});
    stray = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("halt_reset", {22'd0, halted, busy, pc}, 32'd0);
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("drained_2", 32'(ir_q.size() + rw_q.size() + dm_q.size()), 32'd0);

    imem[8'h00] = 16'h4000;
    dwait[8'h00] = 50;
    push_ir(8'h00, 16'h4000, 0);
    run = 1'b1;
    guard = 0;
    while (!dmem_req && guard < 20) begin @(negedge clk); guard++; end
    check("mem_before_reset", {31'd0, dmem_req}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_drop", {6'd0, dmem_req, busy, pc, ir}, 32'd0);
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("stays_idle", {22'd0, busy, imem_req, pc}, 32'd0);
    check("drained_3", 32'(ir_q.size() + rw_q.size() + dm_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_step_sequencer.md
Name: cpu_step_sequencer

Overview:
Multi-cycle instruction sequencer for the 16-bit custom-ISA CPU core. It replaces the free-running single-cycle PC with an explicit FETCH/DECODE/MEM/WB state machine. It owns the program counter and the instruction register, and handshakes with instruction and data memory. It also gates register writes, using the flags and branch-destination code produced by the Control decoder.

Parameters:
PC_W, 8, program counter width; the PC wraps modulo 2^PC_W.
HALT_ADDR, 200, PC value loaded when the halt branch code (6) executes.
INSTR_W, 16, instruction word width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
run  in  1  level; enables fetching of new instructions.
imem_req  out  1  instruction fetch request; held high until acknowledged.
imem_ack  in  1  instruction memory ack; imem_rdata is valid in the same cycle.
imem_rdata  in  INSTR_W  fetched instruction word.
pc  out  PC_W  current program counter; also the fetch address.
ir  out  INSTR_W  latched instruction word, fed to Control.
ir_load  out  1  one-cycle pulse when ir is updated.
reg_write_flag  in  1  from Control.
mem_read_flag  in  1  from Control.
mem_write_flag  in  1  from Control.
branch_dest  in  3  branch code from Control (0 = sequential, 1..5 = conditional/jump, 6 = halt).
branch_taken  in  1  from the ALU/branch unit; sampled in WB.
branch_target  in  PC_W  target PC; sampled in WB.
dmem_req  out  1  data memory request; held high until acknowledged.
dmem_we  out  1  data memory write enable; valid while dmem_req is high.
dmem_ack  in  1  data memory ack.
reg_we  out  1  one-cycle register-file write strobe.
busy  out  1  high in every state except IDLE and HALT.
halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, ir=0. All of imem_req, dmem_req, dmem_we, ir_load, reg_we, busy and halted are 0.
- IDLE:
  - run=1 -> FETCH on the next edge.
  - run=0 -> stay in IDLE.
- FETCH:
  - imem_req=1.
  - On a cycle with imem_ack=1: ir<=imem_rdata, ir_load pulses for one cycle (the cycle after ack, aligned with the new ir), go to DECODE.
  - imem_ack with no outstanding request is ignored.
- DECODE: exactly one cycle to let the Control outputs settle on the new ir.
  - mem_read_flag or mem_write_flag -> MEM.
  - Otherwise -> WB.
- MEM:
  - dmem_req=1.
  - dmem_we = mem_write_flag & ~mem_read_flag; read has priority if both flags are set.
  - Stay in MEM until dmem_ack=1, then go to WB. The ack cycle is the last cycle of dmem_req.
- WB (one cycle):
  - reg_we = reg_write_flag, high for this cycle only.
  - PC update:
    - branch_dest=0 -> pc<=pc+1.
    - branch_dest=1..5 -> pc<=branch_taken ? branch_target : pc+1.
    - branch_dest=6 -> pc<=HALT_ADDR, go to HALT.
    - branch_dest=7 (reserved) -> treated as 0.
  - Next state (if not halting): run=1 -> FETCH, otherwise -> IDLE.
- HALT: halted=1, busy=0, no requests issued. Exited only by reset; run is ignored.
- run dropping mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE. The PC reflects the completed instruction.
- PC arithmetic: pc+1 truncates to PC_W bits, so 2^PC_W-1 wraps to 0.
- Latency with zero-wait memory (ack in the first request cycle):
  - Non-memory instruction: 3 cycles (FETCH, DECODE, WB).
  - Memory instruction: 4 cycles.
  - Each wait cycle on an ack adds one cycle.
- Reset asserted mid-operation: immediate return to reset values; any outstanding request is dropped with no completion.
- Outputs are registered or decoded from state only, with no combinational path from the ack inputs to the req outputs.

Test Plan:
- Reset, then run=1, imem always acking, instruction with all flags 0 and branch_dest=0 -> pc steps 0,1,2 every 3 cycles; ir_load pulses once per instruction; reg_we stays 0.
- reg_write_flag=1, mem_read_flag=1, dmem_ack delayed 2 cycles -> dmem_req high 3 cycles with dmem_we=0; reg_we pulses once in WB; the instruction takes 6 cycles.
- branch_dest=3 with branch_taken=1, branch_target=0x40 -> pc=0x40. The same instruction with branch_taken=0 at pc=0x10 -> pc=0x11.
- branch_dest=6 at pc=5 -> pc=200, halted=1, busy=0. Toggling run produces no further imem_req; only rst_n low clears halted and sets pc=0.
- pc=255 with sequential instruction (PC_W=8) -> pc=0. run dropped during MEM -> the instruction completes WB, then the FSM enters IDLE with busy=0.
- rst_n pulsed low while in MEM with dmem_req=1 -> dmem_req falls asynchronously, pc=0, state IDLE.
